// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_t;

  // Hex code for each (row, column) position of the keypad.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // One-cold active-low strobe pattern for each row index.
  localparam logic [3:0] ROW_STROBE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Index of the lowest active-low column; only meaningful when some column is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    logic [1:0] idx;
    logic       found;
    idx   = 2'd0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!c[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for the raw keypad column pins.
// Resets to all-ones, the idle (pulled-up, no key) column level.
module keypad_scanner_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture of the asynchronous column inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold row strobing, synchronized column
// sampling, press/release debounce and one key code per accepted press.
// Optional build macro KEYPAD_REPEAT_EN: auto-repeat key_valid while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DWELL_W = $clog2(SCAN_CYCLES);

  localparam logic [CNT_W-1:0]   DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  scan_state_t        state_q, state_d;
  logic [1:0]         row_q, row_d;
  logic [1:0]         col_q, col_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         code_d;
  logic               valid_d;
  logic [3:0]         col_sync;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0]   rep_q, rep_d;
`endif

  keypad_scanner_sync #(.W(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (col_sync)
  );

  // State, scan position, counters and registered key outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      row_q     <= '0;
      col_q     <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      key_code  <= code_d;
      key_valid <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    code_d  = key_code;
    valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (col_sync != '1) begin
            state_d = PRESS_DB;
            col_d   = lowest_low(col_sync);
            cnt_d   = '0;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end
      PRESS_DB: begin
        if (!col_sync[col_q]) begin
          if (cnt_q == DB_LAST) begin
            state_d = HELD;
            code_d  = KEYMAP[row_q][col_q];
            valid_d = 1'b1;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = '0;
          row_d   = row_q + 2'd1;
        end
      end
      HELD: begin
        if (col_sync[col_q]) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (rep_q == REP_LAST) begin
            valid_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + CNT_ONE;
          end
`endif
        end
      end
      RELEASE_DB: begin
        if (col_sync[col_q]) begin
          if (cnt_q == DB_LAST) begin
            state_d = SCAN;
            cnt_d   = '0;
            dwell_d = '0;
            row_d   = row_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Bounce back to HELD keeps the repeat phase running.
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Row strobes and held flag follow the registered state directly.
  always_comb begin
    rows     = ROW_STROBE[row_q];
    key_held = (state_q == HELD) || (state_q == RELEASE_DB);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a pin-level keypad model and a
// behavioural reference model. Define KEYPAD_REPEAT_EN to exercise auto-repeat.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DB = 8;
  localparam int RP = 32;

  logic       clk;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0] pressed [4];   // pressed[r][c]
  int         checks;
  int         errors;
  int         pulses;

  keypad_scanner #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a column reads low when a pressed key sits on a driven row.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (rows[r] == 1'b0 && pressed[r][c]) cols[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 scanning, 1 confirming press, 2 key held, 3 confirming release
  int         m_mode, m_row, m_tick, m_cnt, m_col, m_rep;
  logic [3:0] m_code;
  bit         m_valid;
  logic [3:0] seen_hist [2];   // [0] newest pin sample, [1] what the scanner sees
  string      keys = "123A456B789CE0FD";

  function automatic logic [3:0] key_of(input int r, input int c);
    byte ch;
    ch = keys[r * 4 + c];
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_row = 0; m_tick = 0; m_cnt = 0; m_col = 0; m_rep = 0;
      m_code = 4'h0; m_valid = 0;
      seen_hist[0] = 4'hF; seen_hist[1] = 4'hF;
    end else begin
      logic [3:0] seen;
      seen = seen_hist[1];
      seen_hist[1] = seen_hist[0];
      seen_hist[0] = cols;
      m_valid = 0;
      if (m_mode == 0) begin
        if (m_tick == SC - 1) begin
          m_tick = 0;
          if (seen != 4'hF) begin
            for (int c = 3; c >= 0; c--) if (!seen[c]) m_col = c;
            m_mode = 1; m_cnt = 0;
          end else m_row = (m_row + 1) % 4;
        end else m_tick++;
      end else if (m_mode == 1) begin
        if (!seen[m_col]) begin
          if (m_cnt == DB - 1) begin
            m_code = key_of(m_row, m_col); m_valid = 1; m_mode = 2; m_rep = 0;
          end else m_cnt++;
        end else begin
          m_mode = 0; m_cnt = 0; m_tick = 0; m_row = (m_row + 1) % 4;
        end
      end else if (m_mode == 2) begin
        if (seen[m_col]) begin
          m_mode = 3; m_cnt = 0;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          m_rep++;
          if (m_rep == RP) begin m_valid = 1; m_rep = 0; end
`endif
        end
      end else begin
        if (seen[m_col]) begin
          if (m_cnt == DB - 1) begin
            m_mode = 0; m_cnt = 0; m_tick = 0; m_row = (m_row + 1) % 4;
          end else m_cnt++;
        end else m_mode = 2;
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    check("rows", rows, 4'hF & ~(4'b1 << m_row));
    check("key_code", key_code, m_code);
    check("key_valid", key_valid, m_valid);
    check("key_held", key_held, (m_mode == 2 || m_mode == 3));
    if (key_valid === 1'b1) pulses++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick(1);
      if (key_valid) break;
    end
    if (i == budget) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_mode(input string tag, input int mode, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick(1);
      if (m_mode == mode) break;
    end
    if (i == budget) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      tick(1);
      if (!key_held && m_mode == 0) break;
    end
    if (i == budget) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int p0, n;
    checks = 0; errors = 0; pulses = 0;
    release_all();
    reset = 1'b0;
    tick(3);
    check("rst_rows", rows, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    reset = 1'b1;
    tick(2);

    // Async reset in the middle of press debounce.
    pressed[1][2] = 1'b1;
    wait_mode("t1", 1, 60);
    tick(2);
    reset = 1'b0;
    #1;
    check("t1_rows", rows, 4'b1110);
    check("t1_valid", key_valid, 1'b0);
    check("t1_held", key_held, 1'b0);
    tick(2);
    release_all();
    reset = 1'b1;
    tick(4);

    // Single clean press of '8'.
    p0 = pulses;
    pressed[2][1] = 1'b1;
    wait_valid("t2", 60);
    tick(20);
    check("t2_pulses", pulses - p0, 1);
    check("t2_code", key_code, 4'h8);
    check("t2_held", key_held, 1'b1);
    release_all();
    wait_idle("t2_rel", 60);

    // Glitch release inside the debounce window, then a clean press of 'A'.
    p0 = pulses;
    pressed[0][3] = 1'b1;
    wait_mode("t3", 1, 60);
    tick(3);
    release_all();
    tick(3);
    check("t3_glitch_pulses", pulses - p0, 0);
    pressed[0][3] = 1'b1;
    wait_valid("t3", 60);
    check("t3_code", key_code, 4'hA);
    check("t3_pulses", pulses - p0, 1);
    release_all();
    wait_idle("t3_rel", 60);

    // Two columns on row 3: lowest wins; a second key while held is ignored.
    p0 = pulses;
    pressed[3][0] = 1'b1;
    pressed[3][2] = 1'b1;
    wait_valid("t4", 60);
    check("t4_code", key_code, 4'hE);
    pressed[1][1] = 1'b1;
    tick(20);
    check("t4_pulses", pulses - p0, 1);
    check("t4_code_kept", key_code, 4'hE);
    release_all();
    wait_idle("t4_rel", 60);

    // Release bounce keeps the key held; clean release ends it and scan resumes.
    p0 = pulses;
    pressed[3][2] = 1'b1;
    wait_valid("t5", 60);
    tick(3);
    release_all();
    tick(2);
    pressed[3][2] = 1'b1;
    tick(15);
    check("t5_bounce_held", key_held, 1'b1);
    check("t5_pulses", pulses - p0, 1);
    release_all();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      n++;
      if (!key_held) break;
    end
    check("t5_release_cycles", n, 11);
    check("t5_resume_row", rows, 4'b1110);
    tick(5);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat of '5'.
    p0 = pulses;
    pressed[1][1] = 1'b1;
    wait_valid("t6", 60);
    tick(100);
    check("t6_pulses", pulses - p0, 4);
    check("t6_code", key_code, 4'h5);
    release_all();
    wait_idle("t6_rel", 60);
`endif

    // Randomized presses, bounces and multi-key chords against the model.
    for (int it = 0; it < 40; it++) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      pressed[r][c] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      tick($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) begin
        release_all();
        tick($urandom_range(1, 4));
        pressed[r][c] = 1'b1;
        tick($urandom_range(0, 20));
      end
      release_all();
      tick($urandom_range(0, 30));
    end
    wait_idle("rand_end", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
